// File: rtl/gcn_pkg.sv
// Shared types and sizing for the GCN argmax read-out stage.
// Build option ARGMAX_PIPE_EN (see gcn_argmax_reader) does not change anything in this package.
package gcn_pkg;

   localparam int FEATURE_ROWS          = 6;
   localparam int WEIGHT_COLS           = 3;
   localparam int DOT_PROD_WIDTH        = 16;
   localparam int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS);
   localparam int MAX_ADDRESS_WIDTH     = 2;

   typedef logic [DOT_PROD_WIDTH-1:0]        dot_t;
   typedef logic [COUNTER_FEATURE_WIDTH-1:0] row_idx_t;
   typedef logic [MAX_ADDRESS_WIDTH-1:0]     cls_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DONE
   } rd_state_t;

endpackage

// File: rtl/argmax_unit.sv
// Combinational argmax over one row of class scores.
// Scores are unsigned; ties go to the lowest index, so an all-equal row yields 0.
module argmax_unit
   import gcn_pkg::*;
(
   input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] scores_i,
   output cls_idx_t                                   idx_o
);

   dot_t best;

   // NOTE: blocking assignments are intended here; the running maximum must update
   // within the same loop pass so that each comparison sees the previous winner.
   always_comb begin
      best  = scores_i[0];
      idx_o = '0;
      for (int c = 1; c < WEIGHT_COLS; c++) begin
         if (scores_i[c] > best) begin
            best  = scores_i[c];
            idx_o = cls_idx_t'(c);
         end
      end
   end

endmodule

// File: rtl/gcn_argmax_reader.sv
// Walks the FM*WM*ADJ result memory row by row and stores the argmax class of every node.
// Defining ARGMAX_PIPE_EN inserts one register stage between the memory and the comparator.
module gcn_argmax_reader
   import gcn_pkg::*;
(
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            ADJ_fm_wm_done,
   input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]      fm_wm_adj_row_mem_out,
   output logic [COUNTER_FEATURE_WIDTH-1:0]                read_MAX_adj_row,
   output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]  max_addi_answer,
   output logic                                            done
);

   rd_state_t state_q, state_d;
   row_idx_t  row_q, row_d;
   logic      done_q, done_d;
   logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] ans_q, ans_d;

   logic      rd_fire;
   logic      wr_en;
   row_idx_t  wr_row;
   cls_idx_t  wr_cls;
   logic      drain_pending;
   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] cmp_data;

`ifdef ARGMAX_PIPE_EN
   logic      pipe_vld_q;
   row_idx_t  pipe_row_q;
   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] pipe_data_q;

   // The valid bit follows rd_fire, so an abort in READ drops it on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_vld_q  <= 1'b0;
         pipe_row_q  <= '0;
         pipe_data_q <= '0;
      end else begin
         pipe_vld_q <= rd_fire;
         if (rd_fire) begin
            pipe_row_q  <= row_q;
            pipe_data_q <= fm_wm_adj_row_mem_out;
         end
      end
   end

   assign cmp_data      = pipe_data_q;
   assign wr_en         = pipe_vld_q;
   assign wr_row        = pipe_row_q;
   assign drain_pending = pipe_vld_q;
`else
   assign cmp_data      = fm_wm_adj_row_mem_out;
   assign wr_en         = rd_fire;
   assign wr_row        = row_q;
   assign drain_pending = 1'b0;
`endif

   argmax_unit u_argmax (
      .scores_i (cmp_data),
      .idx_o    (wr_cls)
   );

   // Row counter is parked at 0 outside READ so the address output needs no extra mux.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      done_d  = done_q;
      rd_fire = 1'b0;
      case (state_q)
         IDLE: begin
            row_d  = '0;
            done_d = 1'b0;
            if (ADJ_fm_wm_done) state_d = READ;
         end
         READ: begin
            if (!ADJ_fm_wm_done) begin
               state_d = IDLE;
               row_d   = '0;
            end else begin
               rd_fire = 1'b1;
               if (row_q == row_idx_t'(FEATURE_ROWS-1)) begin
                  state_d = DONE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (!ADJ_fm_wm_done) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end else if (!drain_pending) begin
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      ans_d = ans_q;
      if (wr_en) ans_d[wr_row] = wr_cls;
   end

   // NOTE: the answer file is a handful of flops that must read 0 straight out of
   // reset, so it is reset like the control state rather than left uninitialised.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         done_q  <= 1'b0;
         ans_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         done_q  <= done_d;
         ans_q   <= ans_d;
      end
   end

   assign read_MAX_adj_row = row_q;
   assign max_addi_answer  = ans_q;
   assign done             = done_q;

endmodule

// File: tb/tb_gcn_argmax_reader.sv
// Directed and randomized bench for gcn_argmax_reader with a value-based argmax reference.
// Latency expectations follow ARGMAX_PIPE_EN when it is defined.
module tb_gcn_argmax_reader;
   import gcn_pkg::*;

`ifdef ARGMAX_PIPE_EN
   localparam int LAT = FEATURE_ROWS + 2;
`else
   localparam int LAT = FEATURE_ROWS + 1;
`endif

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]     mem_out;
   logic [COUNTER_FEATURE_WIDTH-1:0]               addr;
   logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] ans;
   logic                                           done;

   logic [DOT_PROD_WIDTH-1:0]    mem     [FEATURE_ROWS][WEIGHT_COLS];
   logic [MAX_ADDRESS_WIDTH-1:0] exp_ans [FEATURE_ROWS];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   gcn_argmax_reader dut (
      .clk                   (clk),
      .reset                 (reset),
      .ADJ_fm_wm_done        (start),
      .fm_wm_adj_row_mem_out (mem_out),
      .read_MAX_adj_row      (addr),
      .max_addi_answer       (ans),
      .done                  (done)
   );

   // Result memory with a combinational read port.
   always_comb begin
      mem_out = '0;
      if (int'(addr) < FEATURE_ROWS)
         for (int c = 0; c < WEIGHT_COLS; c++) mem_out[c] = mem[addr][c];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: find the largest score, then report the first column holding it.
   function automatic logic [MAX_ADDRESS_WIDTH-1:0] ref_argmax(input int r);
      int maxv;
      maxv = 0;
      for (int c = 0; c < WEIGHT_COLS; c++)
         if (int'(mem[r][c]) > maxv) maxv = int'(mem[r][c]);
      for (int c = 0; c < WEIGHT_COLS; c++)
         if (int'(mem[r][c]) == maxv) return MAX_ADDRESS_WIDTH'(c);
      return '0;
   endfunction

   task automatic compute_expected();
      for (int r = 0; r < FEATURE_ROWS; r++) exp_ans[r] = ref_argmax(r);
   endtask

   task automatic rand_mem(input int maxv);
      for (int r = 0; r < FEATURE_ROWS; r++)
         for (int c = 0; c < WEIGHT_COLS; c++)
            mem[r][c] = DOT_PROD_WIDTH'($urandom_range(maxv, 0));
   endtask

   task automatic check_answers(input string name, input int nrows);
      for (int r = 0; r < nrows; r++)
         check($sformatf("%s ans[%0d]", name, r), 32'(ans[r]), 32'(exp_ans[r]));
   endtask

   // Raise start at a falling edge and follow the pass edge by edge up to done.
   task automatic run_full(input string name);
      compute_expected();
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i <= LAT; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("%s addr@e%0d", name, i), 32'(addr), (i < FEATURE_ROWS) ? i : 0);
         check($sformatf("%s done@e%0d", name, i), 32'(done), (i >= LAT) ? 1 : 0);
      end
      check_answers(name, FEATURE_ROWS);
   endtask

   task automatic finish_run(input string name);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({name, " done drop"}, 32'(done), 0);
      check({name, " addr idle"}, 32'(addr), 0);
      check_answers({name, " kept"}, FEATURE_ROWS);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset held with start high.
      reset = 1'b0;
      start = 1'b1;
      rand_mem(65535);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("rst addr%0d", i), 32'(addr), 0);
         check($sformatf("rst done%0d", i), 32'(done), 0);
         check($sformatf("rst ans%0d", i), 32'(ans), 0);
      end
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      // 2: basic table.
      mem[0] = '{16'd5, 16'd9, 16'd2};
      mem[1] = '{16'd7, 16'd7, 16'd1};
      mem[2] = '{16'd0, 16'd0, 16'd3};
      mem[3] = '{16'd4, 16'd1, 16'd0};
      mem[4] = '{16'd2, 16'd8, 16'd8};
      mem[5] = '{16'd0, 16'd0, 16'd0};
      run_full("basic");
      check("basic const0", 32'(ans[0]), 1);
      check("basic const1", 32'(ans[1]), 0);
      check("basic const2", 32'(ans[2]), 2);
      check("basic const3", 32'(ans[3]), 0);
      check("basic const4", 32'(ans[4]), 1);
      check("basic const5", 32'(ans[5]), 0);
      finish_run("basic");

      // 3: extreme unsigned values.
      rand_mem(65535);
      mem[0] = '{16'hFFFE, 16'hFFFF, 16'h0001};
      mem[1] = '{16'hFFFF, 16'h0000, 16'hFFFF};
      run_full("range");
      check("range row0", 32'(ans[0]), 1);
      check("range row1", 32'(ans[1]), 0);
      finish_run("range");

      // 4: abort while address 3 is on the bus, then a full restart.
      rand_mem(65535);
      compute_expected();
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("abort addr@e%0d", i), 32'(addr), i);
      end
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort done", 32'(done), 0);
      check("abort addr", 32'(addr), 0);
      check_answers("abort partial", 3);
      @(posedge clk);
      @(negedge clk);
      check("abort idle addr", 32'(addr), 0);
      check("abort idle done", 32'(done), 0);
      rand_mem(7);
      run_full("restart");
      finish_run("restart");

      // 5: asynchronous reset in the middle of a pass.
      rand_mem(65535);
      compute_expected();
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("midrst addr before", 32'(addr), 2);
      #2 reset = 1'b0;
      #1;
      check("midrst addr", 32'(addr), 0);
      check("midrst done", 32'(done), 0);
      check("midrst ans", 32'(ans), 0);
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      rand_mem(65535);
      run_full("postrst");

      // 6: start held well past done, then released.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("hold done%0d", i), 32'(done), 1);
         check($sformatf("hold addr%0d", i), 32'(addr), 0);
         check_answers($sformatf("hold%0d", i), FEATURE_ROWS);
      end
      finish_run("hold");

      // Extra randomized passes, small ranges first to provoke ties.
      for (int k = 0; k < 4; k++) begin
         rand_mem((k < 2) ? 3 : 65535);
         run_full($sformatf("rand%0d", k));
         finish_run($sformatf("rand%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
